// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit, each held BAUD_DIV clocks.
// Both outputs come straight from flops; a frame keeps tx_busy high for exactly 10*BAUD_DIV cycles.
module uart_tx_8n1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       uart_txd
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b100
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_q;
  logic [15:0] baud_q;
  logic [15:0] baud_d;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_busy_q;
  logic        uart_txd_q;
  logic        baud_wrap;

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign baud_d    = baud_wrap ? 16'd0 : baud_q + 16'd1;

  assign tx_busy  = tx_busy_q;
  assign uart_txd = uart_txd_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_busy_q  <= 1'b0;
      uart_txd_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          uart_txd_q <= 1'b1;
          tx_busy_q  <= 1'b0;
          baud_q     <= 16'd0;
          bit_q      <= 3'd0;
          if (tx_start) begin
            // Busy and the start bit appear together, so upstream never sees a false idle.
            state_q    <= START;
            shift_q    <= tx_data;
            uart_txd_q <= 1'b0;
            tx_busy_q  <= 1'b1;
          end
        end

        START: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q    <= DATA;
            bit_q      <= 3'd0;
            uart_txd_q <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
          end
        end

        DATA: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            // bit_q names the bit on the line; its wrap from 7 ends the data phase.
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q    <= STOP;
              uart_txd_q <= 1'b1;
            end else begin
              uart_txd_q <= shift_q[0];
              shift_q    <= {1'b0, shift_q[7:1]};
            end
          end
        end

        STOP: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q   <= IDLE;
            tx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q    <= IDLE;
          baud_q     <= 16'd0;
          bit_q      <= 3'd0;
          tx_busy_q  <= 1'b0;
          uart_txd_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1 (BAUD_DIV=4): frame-level line model checked every cycle,
// an independent line decoder, and directed scenarios with hand-computed line patterns.
module tb_uart_tx_8n1;
  localparam int BD    = 4;
  localparam int FRAME = 10 * BD;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_busy;
  logic       uart_txd;

  int tests = 0;
  int fails = 0;

  uart_tx_8n1 #(.BAUD_DIV(BD)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .uart_txd(uart_txd)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: an accepted byte becomes the 10-bit line pattern {1,data,0} that plays
  // out one symbol per BD cycles; busy lasts as long as the pattern.
  int         m_rem   = 0;
  int         m_k     = 0;
  logic [9:0] m_frame = 10'h3FF;
  logic [7:0] exp_q[$];

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_rem = 0;
      exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      m_k++;
    end else if (tx_start) begin
      m_frame = {1'b1, tx_data, 1'b0};
      m_k     = 0;
      m_rem   = FRAME;
      exp_q.push_back(tx_data);
    end
  end

  function automatic logic model_txd();
    return (m_rem > 0) ? m_frame[m_k / BD] : 1'b1;
  endfunction

  always @(negedge sys_clk) begin
    check("cyc_busy", tx_busy, (m_rem > 0));
    check("cyc_txd", uart_txd, model_txd());
  end

  // Line decoder: finds the start edge and samples each symbol mid-bit.
  int         rx_cnt = -1;
  logic [9:0] rx_bits;
  logic [7:0] rx_log[$];

  always @(negedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_cnt = -1;
    end else begin
      if (rx_cnt < 0 && uart_txd == 1'b0) rx_cnt = 0;
      if (rx_cnt >= 0) begin
        if (rx_cnt % BD == BD / 2) rx_bits[rx_cnt / BD] = uart_txd;
        if (rx_cnt == FRAME - 1) begin
          check("rx_stop_bit", rx_bits[9], 1'b1);
          rx_log.push_back(rx_bits[8:1]);
          $display("[TB] %0t rx byte 0x%02h", $time, rx_bits[8:1]);
          check("rx_byte_expected", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) check("rx_byte", rx_bits[8:1], exp_q.pop_front());
          rx_cnt = -1;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  logic cap_txd[0:127];
  int   cap_busy_cnt;
  int   cap_fall;

  // Called at posedge+1 while idle; returns at posedge+1 of frame cycle 0.
  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(posedge sys_clk);
    #1 tx_start = 1'b0;
    $display("[TB] %0t start 0x%02h", $time, b);
    check("busy_after_start", tx_busy, 1'b1);
  endtask

  // Records n cycles from the current one; optionally pulses tx_start at cycle inj.
  task automatic capture(input int n, input int inj, input logic [7:0] inj_data);
    cap_busy_cnt = 0;
    cap_fall     = -1;
    for (int c = 0; c < n; c++) begin
      if (c == inj) begin
        tx_start = 1'b1;
        tx_data  = inj_data;
        $display("[TB] %0t start 0x%02h at frame cycle %0d", $time, inj_data, c);
      end
      if (c == inj + 1) tx_start = 1'b0;
      cap_txd[c] = uart_txd;
      if (tx_busy) cap_busy_cnt++;
      else if (cap_fall < 0) cap_fall = c;
      @(posedge sys_clk);
      #1;
    end
    tx_start = 1'b0;
  endtask

  // seq lists the ten line symbols in transmit order (start bit first).
  task automatic check_line(input string name, input logic [0:9] seq, input bit full);
    for (int i = 0; i < 10; i++)
      for (int j = (full ? 0 : BD / 2); j < (full ? BD : BD / 2 + 1); j++)
        check(name, cap_txd[i * BD + j], seq[i]);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (tx_busy !== 1'b0 && n < limit) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("idle_timeout", (n < limit), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  sums[6];
    logic [383:0] res;
    int           base;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;

    // 0xA5: every cycle of every symbol, busy exactly 40 cycles.
    send(8'hA5);
    capture(44, -1, 8'h00);
    check_line("a5_line", 10'b0101001011, 1'b1);
    check("a5_busy_cycles", cap_busy_cnt, 40);
    check("a5_busy_fall", cap_fall, 40);

    // 0x00 and 0xFF, with tx_data disturbed right after acceptance.
    send(8'h00);
    tx_data = 8'h3C;
    capture(44, -1, 8'h00);
    check_line("zero_line", 10'b0000000001, 1'b0);
    send(8'hFF);
    tx_data = 8'h3C;
    capture(44, -1, 8'h00);
    check_line("ff_line", 10'b0111111111, 1'b0);

    // Start while busy must be ignored.
    send(8'h12);
    capture(48, 10, 8'h34);
    check_line("x12_line", 10'b0010010001, 1'b0);
    check("ignored_busy_fall", cap_fall, 40);
    check("ignored_busy_cycles", cap_busy_cnt, 40);
    check("ignored_line_idle", cap_txd[44], 1'b1);
    check("ignored_last_rx", rx_log[rx_log.size() - 1], 8'h12);

    // Back-to-back: second start issued in the first idle cycle (frame cycle 40).
    send(8'h55);
    capture(84, 40, 8'hAA);
    check("b2b_first_idle", cap_fall, 40);
    check("b2b_gap_high", cap_txd[40], 1'b1);
    check("b2b_second_start", cap_txd[41], 1'b0);
    check("b2b_busy_cycles", cap_busy_cnt, 80);
    check("b2b_rx_first", rx_log[rx_log.size() - 2], 8'h55);
    check("b2b_rx_second", rx_log[rx_log.size() - 1], 8'hAA);
    wait_idle(100);

    // Asynchronous reset pulse during data bit 3 (frame cycles 16..19).
    base = rx_log.size();
    send(8'hC3);
    repeat (17) @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    $display("[TB] %0t reset pulse mid-frame", $time);
    #1;
    check("abort_txd", uart_txd, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    #1 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    capture(8, -1, 8'h00);
    check("abort_stays_idle", cap_busy_cnt, 0);
    send(8'h81);
    capture(44, -1, 8'h00);
    check_line("x81_line", 10'b0100000011, 1'b0);
    check("abort_rx_count", rx_log.size(), base + 1);
    check("abort_rx_byte", rx_log[rx_log.size() - 1], 8'h81);

    // Upstream-style sender: 48 bytes of six 64-bit sums, low byte first.
    sums[0] = 64'h0123_4567_89AB_CDEF;
    sums[1] = 64'hFEDC_BA98_7654_3210;
    sums[2] = 64'h0000_0000_0000_0001;
    sums[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    sums[4] = 64'hDEAD_BEEF_CAFE_F00D;
    sums[5] = 64'h8000_0000_0000_0080;
    for (int k = 0; k < 6; k++) res[64 * k +: 64] = sums[k];
    base = rx_log.size();
    for (int i = 0; i < 48; i++) begin
      wait_idle(2 * FRAME);
      send(res[8 * i +: 8]);
    end
    wait_idle(2 * FRAME);
    repeat (4) @(posedge sys_clk);
    #1;
    check("int_rx_count", rx_log.size(), base + 48);
    if (rx_log.size() == base + 48)
      for (int i = 0; i < 48; i++) check("int_rx_byte", rx_log[base + i], res[8 * i +: 8]);
    check("int_first_byte", rx_log[base], 8'hEF);
    check("pending_bytes", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
